action_engine: RTL and testbench

- Per-stage action unit of the match-action pipeline.
- Takes the action word from the lookup engine together with the matching PHV.
- Modifies header containers or metadata according to a single opcode, then forwards the PHV to the next stage.
- Fixed latency of 2 cycles, fully pipelined: accepts one PHV per cycle, no backpressure.

---
 rtl/action_engine.sv | 142 ++++++++++++++
 tb/tb_action_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/action_engine.sv
// action_engine: two-cycle match-action stage applying one opcode to a PHV.
// Define ACTION_ENGINE_STATEFUL_EN to build the 32x32 stateful memory used by load/store.
module action_engine #(
  parameter int unsigned STAGE      = 0,
  parameter int unsigned PHV_LEN    = 1579,
  parameter int unsigned ACTION_LEN = 25
) (
  input  logic                  axis_clk,
  input  logic                  aresetn,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_in_valid,
  input  logic [PHV_LEN-1:0]    phv_in,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid
);

  localparam int unsigned IdxW = $clog2(PHV_LEN);

  // Stage index is informational only.
  logic [31:0] w_unused_stage;
  assign w_unused_stage = 32'(STAGE);

  logic [ACTION_LEN-1:0] r_action;
  logic [PHV_LEN-1:0]    r_phv;
  logic                  r_valid;

  logic [3:0]         w_op;
  logic [4:0]         w_sel_a, w_sel_b;
  logic               w_a_ok, w_b_ok;
  logic [47:0]        w_a, w_b, w_imm, w_new;
  logic               w_wr;
  logic [PHV_LEN-1:0] w_result;

  function automatic logic [IdxW-1:0] cont_msb(input logic [4:0] sel);
    int unsigned idx;
    idx = 32'(sel[2:0]);
    case (sel[4:3])
      2'b00:   return IdxW'(PHV_LEN - 1 - 32 * idx);
      2'b01:   return IdxW'(PHV_LEN - 1 - 256 - 16 * idx);
      default: return IdxW'(PHV_LEN - 1 - 384 - 48 * idx);
    endcase
  endfunction

  // Containers are read zero-extended to 48 bits.
  function automatic logic [47:0] rd_cont(input logic [PHV_LEN-1:0] phv, input logic [4:0] sel);
    logic [IdxW-1:0] msb;
    msb = cont_msb(sel);
    case (sel[4:3])
      2'b00:   return {16'b0, phv[msb -: 32]};
      2'b01:   return {32'b0, phv[msb -: 16]};
      2'b10:   return phv[msb -: 48];
      default: return '0;
    endcase
  endfunction

  // Writing truncates to the container width, which gives the modular wrap.
  function automatic logic [PHV_LEN-1:0] wr_cont(input logic [PHV_LEN-1:0] phv,
                                                 input logic [4:0] sel, input logic [47:0] val);
    logic [PHV_LEN-1:0] p;
    logic [IdxW-1:0]    msb;
    p   = phv;
    msb = cont_msb(sel);
    case (sel[4:3])
      2'b00:   p[msb -: 32] = val[31:0];
      2'b01:   p[msb -: 16] = val[15:0];
      2'b10:   p[msb -: 48] = val;
      default: ;
    endcase
    return p;
  endfunction

  assign w_op    = r_action[24:21];
  assign w_sel_a = r_action[20:16];
  assign w_sel_b = r_action[15:11];
  assign w_a_ok  = (w_sel_a[4:3] != 2'b11);
  assign w_b_ok  = (w_sel_b[4:3] != 2'b11);
  assign w_a     = rd_cont(r_phv, w_sel_a);
  assign w_b     = rd_cont(r_phv, w_sel_b);
  assign w_imm   = {32'b0, r_action[15:0]};

`ifdef ACTION_ENGINE_STATEFUL_EN
  logic [31:0] r_mem [32];
  logic        w_mem_we;
  logic [4:0]  w_addr;

  assign w_addr   = r_action[4:0];
  assign w_mem_we = r_valid && (w_op == 4'b0110) && w_a_ok;

  // Registered write plus combinational read gives write-first behaviour for back-to-back ops.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < 32; k++) r_mem[k] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_addr] <= w_a[31:0];
    end
  end
`endif

  always_comb begin
    w_result = r_phv;
    w_new    = w_a;
    w_wr     = 1'b0;
    case (w_op)
      4'b0001: begin w_new = w_a + w_b;   w_wr = w_a_ok && w_b_ok; end
      4'b0010: begin w_new = w_a - w_b;   w_wr = w_a_ok && w_b_ok; end
      4'b0011: begin w_new = w_a + w_imm; w_wr = w_a_ok; end
      4'b0100: begin w_new = w_a - w_imm; w_wr = w_a_ok; end
`ifdef ACTION_ENGINE_STATEFUL_EN
      4'b0101: begin w_new = {16'b0, r_mem[w_addr]}; w_wr = w_a_ok; end
`endif
      4'b1000: w_result[255:248] = r_action[20:13];
      4'b1001: w_result[247]     = r_action[12];
      default: ;
    endcase
    if (w_wr) w_result = wr_cont(r_phv, w_sel_a, w_new);
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid  <= 1'b0;
      r_action <= '0;
      r_phv    <= '0;
    end else begin
      r_valid <= action_in_valid;
      if (action_in_valid) begin
        r_action <= action_in;
        r_phv    <= phv_in;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
    end else begin
      phv_out_valid <= r_valid;
      if (r_valid) phv_out <= w_result;
    end
  end

endmodule

// File: tb/tb_action_engine.sv
// Scoreboard bench for action_engine: directed plan cases plus randomized actions
// checked against a field-level reference model.
module tb_action_engine;

  localparam int PHV_LEN = 1579;
  localparam int L4B0    = 1578 - 31;
  localparam int L4B1    = 1578 - 32 - 31;

  logic               axis_clk = 1'b0;
  logic               aresetn;
  logic [24:0]        action_in;
  logic               action_in_valid;
  logic [PHV_LEN-1:0] phv_in;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;

  action_engine #(.STAGE(0), .PHV_LEN(PHV_LEN), .ACTION_LEN(25)) dut (
    .axis_clk        (axis_clk),
    .aresetn         (aresetn),
    .action_in       (action_in),
    .action_in_valid (action_in_valid),
    .phv_in          (phv_in),
    .phv_out         (phv_out),
    .phv_out_valid   (phv_out_valid)
  );

  always #5 axis_clk = ~axis_clk;

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  typedef struct {
    logic [PHV_LEN-1:0] phv;
    int                 due;
    int                 id;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          next_id  = 0;
  logic [31:0] mmem [32];

  task automatic chk_int(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_phv(input string name, input int id, input logic [PHV_LEN-1:0] got,
                         input logic [PHV_LEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s id=%0d got_4b01=%h exp_4b01=%h got_md=%h exp_md=%h diffbits=%0d",
               name, id, got[1578:1515], exp[1578:1515], got[255:247], exp[255:247],
               $countones(got ^ exp));
    end
  endtask

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] r;
    r = '0;
    repeat (50) r = {r[PHV_LEN-33:0], 32'($urandom)};
    return r;
  endfunction

  // Location of a container from its type/index select; width 0 means invalid.
  function automatic void loc(input logic [4:0] sel, output int lsb, output int w);
    int i;
    i = int'(sel[2:0]);
    case (sel[4:3])
      2'b00:   begin w = 32; lsb = 1578 - 32 * i - 31; end
      2'b01:   begin w = 16; lsb = 1322 - 16 * i - 15; end
      2'b10:   begin w = 48; lsb = 1194 - 48 * i - 47; end
      default: begin w = 0;  lsb = 0; end
    endcase
  endfunction

  function automatic longint unsigned get(input logic [PHV_LEN-1:0] p, input int lsb, input int w);
    longint unsigned mask;
    mask = (64'd1 << w) - 1;
    return 64'(p >> lsb) & mask;
  endfunction

  function automatic logic [PHV_LEN-1:0] put(input logic [PHV_LEN-1:0] p, input int lsb,
                                             input int w, input longint unsigned v);
    longint unsigned mask;
    mask = (64'd1 << w) - 1;
    return (p & ~(PHV_LEN'(mask) << lsb)) | (PHV_LEN'(v & mask) << lsb);
  endfunction

  // Reference model: applies one action in program order, updating the model memory.
  function automatic logic [PHV_LEN-1:0] model(input logic [PHV_LEN-1:0] phv,
                                               input logic [24:0] act);
    logic [PHV_LEN-1:0] r;
    int la, wa, lb, wb, op;
    longint unsigned a, b, m;
    r  = phv;
    op = int'(act[24:21]);
    loc(act[20:16], la, wa);
    loc(act[15:11], lb, wb);
    m = 64'd1 << wa;
    a = (wa != 0) ? get(phv, la, wa) : 0;
    case (op)
      1, 2: if (wa != 0 && wb != 0) begin
        b = get(phv, lb, wb) % m;
        r = put(r, la, wa, (op == 1) ? (a + b) % m : (a + m - b) % m);
      end
      3, 4: if (wa != 0) begin
        b = 64'(act[15:0]) % m;
        r = put(r, la, wa, (op == 3) ? (a + b) % m : (a + m - b) % m);
      end
`ifdef ACTION_ENGINE_STATEFUL_EN
      5: if (wa != 0) r = put(r, la, wa, 64'(mmem[act[4:0]]) % m);
      6: if (wa != 0) mmem[act[4:0]] = a[31:0];
`endif
      8: r[255:248] = act[20:13];
      9: r[247] = act[12];
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [24:0] act, input logic [PHV_LEN-1:0] phv,
                       input logic [PHV_LEN-1:0] hand, input bit use_hand);
    logic [PHV_LEN-1:0] m;
    exp_t e;
    m = model(phv, act);
    @(negedge axis_clk);
    action_in       = act;
    phv_in          = phv;
    action_in_valid = 1'b1;
    e.phv = use_hand ? hand : m;
    e.due = cyc + 2;
    e.id  = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge axis_clk);
      action_in_valid = 1'b0;
      action_in       = 25'($urandom);
      phv_in          = rand_phv();
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a PHV.
  logic [PHV_LEN-1:0] last_out = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge axis_clk);
      if (!aresetn) begin
        last_out = '0;
      end else if (phv_out_valid) begin
        if (sb.size() == 0) begin
          chk_int("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk_int("latency", cyc, e.due);
          chk_phv("phv_out", e.id, phv_out, e.phv);
        end
        last_out = phv_out;
      end else begin
        chk_phv("hold", -1, phv_out, last_out);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          chk_int("missing_output", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PHV_LEN-1:0] p, e;
    logic [24:0] a;
    for (int k = 0; k < 32; k++) mmem[k] = '0;
    aresetn         = 1'b0;
    action_in_valid = 1'b0;
    action_in       = '0;
    phv_in          = '0;
    repeat (2) @(negedge axis_clk);
    chk_int("reset_valid", longint'(phv_out_valid), 0);
    chk_phv("reset_phv", -1, phv_out, '0);
    #2 aresetn = 1'b1;
    idle(3);
    chk_phv("idle_phv", -1, phv_out, '0);

    issue(25'h0, PHV_LEN'(2), PHV_LEN'(2), 1'b1);
    idle(3);

    // add, then add with wrap
    a = {4'b0001, 5'b00000, 5'b00001, 11'b0};
    p = put(put(rand_phv(), L4B0, 32, 64'hF000_0000), L4B1, 32, 5);
    issue(a, p, put(p, L4B0, 32, 64'hF000_0005), 1'b1);
    p = put(put(rand_phv(), L4B0, 32, 64'hFFFF_FFFF), L4B1, 32, 1);
    issue(a, p, put(p, L4B0, 32, 0), 1'b1);

    // addi / subi
    p = put(rand_phv(), L4B0, 32, 64'hF000_0000);
    issue({4'b0011, 5'b00000, 16'h0003}, p, put(p, L4B0, 32, 64'hF000_0003), 1'b1);
    p = put(rand_phv(), L4B0, 32, 0);
    issue({4'b0100, 5'b00000, 16'h0001}, p, put(p, L4B0, 32, 64'hFFFF_FFFF), 1'b1);

    // redirect / discard
    p = rand_phv();
    e = p; e[255:248] = 8'hFF;
    issue({4'b1000, 8'hFF, 13'b0}, p, e, 1'b1);
    p = rand_phv(); p[247] = 1'b0;
    e = p; e[247] = 1'b1;
    issue({4'b1001, 8'hFF, 1'b1, 12'b0}, p, e, 1'b1);

    // store then load of the same address on the next cycle
    p = put(rand_phv(), L4B0, 32, 64'hF000_0000);
    issue({4'b0110, 5'b00000, 16'h0003}, p, p, 1'b1);
    p = rand_phv();
`ifdef ACTION_ENGINE_STATEFUL_EN
    e = put(p, L4B1, 32, 64'hF000_0000);
`else
    e = p;
`endif
    issue({4'b0101, 5'b00001, 16'h0003}, p, e, 1'b1);
    idle(4);

    // reset mid-stream drops in-flight PHVs
    issue(25'($urandom), rand_phv(), '0, 1'b0);
    issue(25'($urandom), rand_phv(), '0, 1'b0);
    issue(25'($urandom), rand_phv(), '0, 1'b0);
    #2 aresetn = 1'b0;
    sb.delete();
    for (int k = 0; k < 32; k++) mmem[k] = '0;
    @(negedge axis_clk);
    action_in_valid = 1'b0;
    chk_int("midrst_valid", longint'(phv_out_valid), 0);
    chk_phv("midrst_phv", -1, phv_out, '0);
    #2 aresetn = 1'b1;
    idle(4);

    for (int n = 0; n < 300; n++) begin
      a = 25'($urandom);
      if ((a[24:21] == 4'b0101 || a[24:21] == 4'b0110) && $urandom_range(0, 1) == 1)
        a[4:2] = 3'b000;
      issue(a, rand_phv(), '0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
    end
    idle(5);
    chk_int("drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
